// File: rtl/clusterop2_prod_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : clusterop2_prod_accum_if
//  Description : Valid/ready stream carrying a signed word, a cluster id and a
//                last marker. The product input and the drained-sum output of
//                clusterop2_prod_accum each use one instance.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clusterop2_prod_accum_if #(
    parameter int DATA_WIDTH = 17,
    parameter int ID_WIDTH   = 2
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
    logic                  ready;

    // Producer side of the stream
    modport master (
        output valid,
        output data,
        output id,
        output last,
        input  ready
    );

    // Consumer side of the stream
    modport slave (
        input  valid,
        input  data,
        input  id,
        input  last,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/clusterop2_prod_accum.sv
`default_nettype none
// ============================================================================
//  Module      : clusterop2_prod_accum
//  Description : Per-cluster accumulator behind the clusterOp2 17sx9ns
//                multiplier. Signed products tagged with a cluster id are
//                summed into NUM_CLUSTERS accumulators. A product carrying the
//                last marker ends the frame: every sum is drained in id order
//                over a valid/ready port, then all state clears for the next
//                frame.
//                Build option: define CLUSTEROP2_ACC_SAT_EN to saturate sums
//                and raise a sticky overflow flag; otherwise sums wrap and the
//                overflow flag is held at 0.
//                Reset rst_n is synchronous and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module clusterop2_prod_accum #(
    parameter int DIN_WIDTH    = 17,
    parameter int NUM_CLUSTERS = 4,
    parameter int ID_WIDTH     = 2,
    parameter int ACC_WIDTH    = 24
) (
    input  wire                         clk,
    input  wire                         rst_n,
    input  wire                         i_ce,
    clusterop2_prod_accum_if.slave      i_prod,
    clusterop2_prod_accum_if.master     o_sum,
    output logic                        o_overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_CLUSTERS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                 r_state;
    logic [ACC_WIDTH-1:0]       r_acc [NUM_CLUSTERS];
    logic [ID_WIDTH-1:0]        r_k;
    logic                       r_out_valid;
    logic [ACC_WIDTH-1:0]       r_out_data;
    logic [ID_WIDTH-1:0]        r_out_id;
    logic                       r_out_last;
    logic                       r_overflow;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_xfer;
    logic [ACC_WIDTH-1:0]       w_acc_sel;
    logic [ACC_WIDTH-1:0]       w_sum_res;
    logic                       w_ovf_set;
    logic [ACC_WIDTH-1:0]       w_acc0_next;
    logic [ID_WIDTH-1:0]        w_k_next;

    // Readiness depends on state and reset only, so it drops the moment
    // reset is asserted rather than a cycle later.
    assign w_in_ready = (r_state == c_ST_ACCUM) && rst_n;
    assign w_accept   = i_ce && i_prod.valid && w_in_ready;
    assign w_xfer     = i_ce && r_out_valid && o_sum.ready;

    // Read side of the single-cycle read-modify-write on the target cluster
    assign w_acc_sel  = r_acc[i_prod.id];

`ifdef CLUSTEROP2_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0]         w_acc_ext;
    logic [ACC_WIDTH:0]         w_din_ext;
    logic [ACC_WIDTH:0]         w_sum_wide;
    logic                       w_clamp;

    // One guard bit above the accumulator exposes signed overflow: the two
    // top bits of the widened sum disagree exactly when it is out of range.
    assign w_acc_ext  = {w_acc_sel[ACC_WIDTH-1], w_acc_sel};
    assign w_din_ext  = {{(ACC_WIDTH+1-DIN_WIDTH){i_prod.data[DIN_WIDTH-1]}}, i_prod.data};
    assign w_sum_wide = w_acc_ext + w_din_ext;
    assign w_clamp    = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];

    // The guard bit holds the true sign, so it picks the clamp direction
    assign w_sum_res  = !w_clamp              ? w_sum_wide[ACC_WIDTH-1:0] :
                        w_sum_wide[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
    assign w_ovf_set  = w_clamp;
`else
    logic [ACC_WIDTH-1:0]       w_din_ext;

    // Wrapping mode: the guard bit would be discarded anyway, so the sum is
    // formed directly at accumulator width (identical modulo 2^ACC_WIDTH).
    assign w_din_ext  = {{(ACC_WIDTH-DIN_WIDTH){i_prod.data[DIN_WIDTH-1]}}, i_prod.data};
    assign w_sum_res  = w_acc_sel + w_din_ext;
    assign w_ovf_set  = 1'b0;
`endif

    // The first drained word must already include the frame's last product
    // when that product targets cluster 0, so it is forwarded here.
    assign w_acc0_next = (i_prod.id == '0) ? w_sum_res : r_acc[0];
    assign w_k_next    = r_k + 1'b1;

    // ------------------------------------------------------------------------
    // Accumulate / drain state machine with registered output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_ACCUM;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < NUM_CLUSTERS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (i_ce) begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc[i_prod.id] <= w_sum_res;
                        if (w_ovf_set) begin
                            r_overflow <= 1'b1;
                        end
                        if (i_prod.last) begin
                            r_state     <= c_ST_DRAIN;
                            r_k         <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_acc0_next;
                            r_out_id    <= '0;
                            r_out_last  <= (c_LAST_ID == '0);
                        end
                    end
                end

                c_ST_DRAIN: begin
                    if (w_xfer) begin
                        if (r_out_last) begin
                            // Drain complete: start the next frame from zero
                            r_state     <= c_ST_ACCUM;
                            r_k         <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_id    <= '0;
                            r_out_last  <= 1'b0;
                            r_overflow  <= 1'b0;
                            for (int i = 0; i < NUM_CLUSTERS; i++) begin
                                r_acc[i] <= '0;
                            end
                        end else begin
                            r_k         <= w_k_next;
                            r_out_data  <= r_acc[w_k_next];
                            r_out_id    <= w_k_next;
                            r_out_last  <= (w_k_next == c_LAST_ID);
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_ACCUM;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------------
    assign i_prod.ready = w_in_ready;
    assign o_sum.valid  = r_out_valid;
    assign o_sum.data   = r_out_data;
    assign o_sum.id     = r_out_id;
    assign o_sum.last   = r_out_last;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire
